// File: rtl/pulse_chk_pkg.sv
// Shared types and constants for the single-wire strobe pulse checker.
// Holds the receiver FSM state encoding and the sticky error codes.
package pulse_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP,
    WAIT_LOW
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_GAP   = 2'd3;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pulse_checker.sv
// Receive-side checker for fixed-shape strobe pulses: HIGH_LEN high samples
// followed by at least LOW_LEN low samples. Flags malformed pulses and counts both kinds.
module pulse_checker
  import pulse_chk_pkg::*;
#(
  parameter int HIGH_LEN = 3,
  parameter int LOW_LEN  = 2,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             DIN,
  input  logic             CLR,
  output logic             PULSE_OK,
  output logic             ERR,
  output logic [1:0]       ERR_CODE,
  output logic             BUSY,
  output logic [CNT_W-1:0] OK_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int MAX_LEN = (HIGH_LEN > LOW_LEN) ? HIGH_LEN : LOW_LEN;
  localparam int CW      = $clog2(MAX_LEN + 2);
  localparam logic [CW-1:0] HIGH_LEN_C = CW'(HIGH_LEN);
  localparam logic [CW-1:0] LOW_LEN_C  = CW'(LOW_LEN);

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic          valid_q, valid_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          busy_q, busy_d;
  logic [1:0]    evt_code;

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    valid_d  = valid_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    evt_code = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (DIN) begin
          state_d = HIGH;
          hcnt_d  = CW'(1);
        end
      end
      HIGH: begin
        if (DIN) begin
          if (hcnt_q < HIGH_LEN_C) begin
            hcnt_d = hcnt_q + CW'(1);
          end else begin
            err_d    = 1'b1;
            evt_code = ERR_LONG;
            state_d  = WAIT_LOW;
          end
        end else begin
          valid_d = (hcnt_q == HIGH_LEN_C);
          lcnt_d  = CW'(1);
          if (hcnt_q < HIGH_LEN_C) begin
            err_d    = 1'b1;
            evt_code = ERR_SHORT;
          end
          // A one-sample gap is already complete on the falling-edge sample.
          if (LOW_LEN == 1) begin
            state_d = IDLE;
            ok_d    = (hcnt_q == HIGH_LEN_C);
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (DIN) begin
          err_d    = 1'b1;
          evt_code = ERR_GAP;
          state_d  = HIGH;
          hcnt_d   = CW'(1);
          valid_d  = 1'b0;
        end else if ((lcnt_q + CW'(1)) >= LOW_LEN_C) begin
          state_d = IDLE;
          ok_d    = valid_q;
        end else begin
          lcnt_d = lcnt_q + CW'(1);
        end
      end
      WAIT_LOW: begin
        if (!DIN) begin
          valid_d = 1'b0;
          lcnt_d  = CW'(1);
          state_d = (LOW_LEN == 1) ? IDLE : GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    code_d = code_q;
    if (err_d) begin
      code_d = evt_code;
    end
    if (CLR) begin
      code_d = ERR_NONE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
    end
  end

  // Counters take the next-cycle strobes so they update on the same edge.
  sat_cnt #(.W(CNT_W)) u_ok_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (CLR),
    .inc  (ok_d),
    .q    (OK_CNT)
  );

  sat_cnt #(.W(CNT_W)) u_err_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (CLR),
    .inc  (err_d),
    .q    (ERR_CNT)
  );

  assign PULSE_OK = ok_q;
  assign ERR      = err_q;
  assign ERR_CODE = code_q;
  assign BUSY     = busy_q;

endmodule
